// File: rtl/jtshouse_cus30_pkg.sv
// Shared types and helpers for the CUS30 RAM port arbiter.
package jtshouse_cus30_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        LATCH,
        DONE,
        GAP
    } state_t;

    typedef logic [1:0] req_t;

    localparam req_t REQ_MAIN = 2'd0;
    localparam req_t REQ_SUB  = 2'd1;
    localparam req_t REQ_SND  = 2'd2;

    function automatic req_t next_req(input req_t r);
        return (r == REQ_SND) ? REQ_MAIN : req_t'(r + 2'd1);
    endfunction

    function automatic logic is_pending(input logic [2:0] p, input req_t r);
        case (r)
            REQ_MAIN: return p[0];
            REQ_SUB:  return p[1];
            REQ_SND:  return p[2];
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jtshouse_cus30_arb_rr.sv
// Round-robin picker for main/sub/snd with its rotating priority pointer.
// JTSHOUSE_CUS30_SNDPRIO_EN makes snd fixed-highest and rotates only main/sub.
module jtshouse_cus30_rr
    import jtshouse_cus30_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pending,
    input  logic       enable,
    input  req_t       last,
    output req_t       grant,
    output logic       valid
);

    req_t ptr;

`ifdef JTSHOUSE_CUS30_SNDPRIO_EN
    req_t other;

    assign other = (ptr == REQ_MAIN) ? REQ_SUB : REQ_MAIN;

    always_comb begin
        grant = ptr;
        valid = 1'b0;
        if (pending[2]) begin
            grant = REQ_SND;
            valid = 1'b1;
        end else if (is_pending(pending, ptr)) begin
            grant = ptr;
            valid = 1'b1;
        end else if (is_pending(pending, other)) begin
            grant = other;
            valid = 1'b1;
        end
    end

    // snd grants leave the main/sub rotation untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_MAIN;
        end else if (enable && last != REQ_SND) begin
            ptr <= (last == REQ_MAIN) ? REQ_SUB : REQ_MAIN;
        end
    end
`else
    req_t c1, c2;

    assign c1 = next_req(ptr);
    assign c2 = next_req(c1);

    always_comb begin
        grant = ptr;
        valid = 1'b0;
        if (is_pending(pending, ptr)) begin
            grant = ptr;
            valid = 1'b1;
        end else if (is_pending(pending, c1)) begin
            grant = c1;
            valid = 1'b1;
        end else if (is_pending(pending, c2)) begin
            grant = c2;
            valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_MAIN;
        end else if (enable) begin
            ptr <= next_req(last);
        end
    end
`endif

endmodule

// File: rtl/jtshouse_cus30_arb.sv
// Shares the CUS30 wave/MMR RAM port between main, sub and sound CPUs.
// Optional JTSHOUSE_CUS30_SNDPRIO_EN gives the sound CPU fixed priority.
module jtshouse_cus30_arb
    import jtshouse_cus30_pkg::*;
#(
    parameter int SND_AW = 16,
    parameter int HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              main_cs,
    input  logic              main_rnw,
    input  logic [9:0]        main_addr,
    input  logic [7:0]        main_dout,
    output logic [7:0]        main_din,
    output logic              main_ok,

    input  logic              sub_cs,
    input  logic              sub_rnw,
    input  logic [9:0]        sub_addr,
    input  logic [7:0]        sub_dout,
    output logic [7:0]        sub_din,
    output logic              sub_ok,

    input  logic              snd_cs,
    input  logic              snd_rnw,
    input  logic [SND_AW-1:0] snd_addr,
    input  logic [7:0]        snd_dout,
    output logic [7:0]        snd_din,
    output logic              snd_ok,

    output logic              bsel,
    output logic              bcs,
    output logic              brnw,
    output logic [9:0]        baddr,
    output logic [7:0]        bdout,
    output logic              scs,
    output logic              srnw,
    output logic [SND_AW-1:0] saddr,
    output logic [7:0]        sdout,
    input  logic [7:0]        xdin
);

    localparam logic [1:0] GAP_LAST = 2'(HOLD - 1);

    state_t     state, state_nx;
    req_t       grant, rr_grant;
    logic       rr_valid;
    logic [1:0] gap_cnt;
    logic [2:0] pending;

    assign pending = {snd_cs & ~snd_ok, sub_cs & ~sub_ok, main_cs & ~main_ok};

    jtshouse_cus30_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .pending (pending),
        .enable  (state == DONE),
        .last    (grant),
        .grant   (rr_grant),
        .valid   (rr_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rr_valid) state_nx = ACC;
            ACC:     state_nx = LATCH;
            LATCH:   state_nx = DONE;
            DONE:    state_nx = (HOLD == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ok is only raised for a requester still holding cs when its access finishes
    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= REQ_MAIN;
            gap_cnt  <= 2'd0;
            main_ok  <= 1'b0;
            sub_ok   <= 1'b0;
            snd_ok   <= 1'b0;
            main_din <= 8'd0;
            sub_din  <= 8'd0;
            snd_din  <= 8'd0;
            bsel     <= 1'b0;
            bcs      <= 1'b0;
            brnw     <= 1'b1;
            baddr    <= 10'd0;
            bdout    <= 8'd0;
            scs      <= 1'b0;
            srnw     <= 1'b1;
            saddr    <= '0;
            sdout    <= 8'd0;
        end else begin
            main_ok <= main_cs & (main_ok | (state == LATCH && grant == REQ_MAIN));
            sub_ok  <= sub_cs  & (sub_ok  | (state == LATCH && grant == REQ_SUB));
            snd_ok  <= snd_cs  & (snd_ok  | (state == LATCH && grant == REQ_SND));
            case (state)
                IDLE: if (rr_valid) begin
                    grant <= rr_grant;
                    if (rr_grant == REQ_SND) begin
                        bsel  <= 1'b0;
                        scs   <= 1'b1;
                        srnw  <= snd_rnw;
                        saddr <= snd_addr;
                        sdout <= snd_dout;
                    end else begin
                        bsel  <= 1'b1;
                        bcs   <= 1'b1;
                        brnw  <= (rr_grant == REQ_SUB) ? sub_rnw  : main_rnw;
                        baddr <= (rr_grant == REQ_SUB) ? sub_addr : main_addr;
                        bdout <= (rr_grant == REQ_SUB) ? sub_dout : main_dout;
                    end
                end
                ACC: begin
                    bcs <= 1'b0;
                    scs <= 1'b0;
                end
                LATCH: if ((grant == REQ_SND) ? srnw : brnw) begin
                    case (grant)
                        REQ_MAIN: main_din <= xdin;
                        REQ_SUB:  sub_din  <= xdin;
                        default:  snd_din  <= xdin;
                    endcase
                end
                DONE:    gap_cnt <= 2'd0;
                GAP:     gap_cnt <= gap_cnt + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtshouse_cus30_arb.sv
// Directed self-checking bench for jtshouse_cus30_arb with a small CUS30 RAM model.
module tb_jtshouse_cus30_arb;

    localparam int M = 0;
    localparam int S = 1;
    localparam int N = 2;

    logic        clk, rst;
    logic        main_cs, main_rnw, main_ok;
    logic [9:0]  main_addr;
    logic [7:0]  main_dout, main_din;
    logic        sub_cs, sub_rnw, sub_ok;
    logic [9:0]  sub_addr;
    logic [7:0]  sub_dout, sub_din;
    logic        snd_cs, snd_rnw, snd_ok;
    logic [15:0] snd_addr;
    logic [7:0]  snd_dout, snd_din;
    logic        bsel, bcs, brnw, scs, srnw;
    logic [9:0]  baddr;
    logic [7:0]  bdout, sdout;
    logic [15:0] saddr;
    logic [7:0]  xdin;

    int checks = 0;
    int errors = 0;
    int bcs_cycles = 0;
    int scs_cycles = 0;
    int overlap = 0;

    logic [7:0] ram [0:1023];
    logic [9:0] ram_addr;

    jtshouse_cus30_arb dut (
        .clk(clk), .rst(rst),
        .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr),
        .main_dout(main_dout), .main_din(main_din), .main_ok(main_ok),
        .sub_cs(sub_cs), .sub_rnw(sub_rnw), .sub_addr(sub_addr),
        .sub_dout(sub_dout), .sub_din(sub_din), .sub_ok(sub_ok),
        .snd_cs(snd_cs), .snd_rnw(snd_rnw), .snd_addr(snd_addr),
        .snd_dout(snd_dout), .snd_din(snd_din), .snd_ok(snd_ok),
        .bsel(bsel), .bcs(bcs), .brnw(brnw), .baddr(baddr), .bdout(bdout),
        .scs(scs), .srnw(srnw), .saddr(saddr), .sdout(sdout), .xdin(xdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten RAM reads back addr^8'h1B, so 10'h041 holds 8'h5A
    assign ram_addr = bsel ? baddr : saddr[9:0];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i ^ 8'h1B);
        end else if ((bsel & bcs & ~brnw) | (~bsel & scs & ~srnw)) begin
            ram[ram_addr] <= bsel ? bdout : sdout;
        end
        xdin <= ram[ram_addr];
    end

    always @(posedge clk) begin
        if (bcs) bcs_cycles++;
        if (scs) scs_cycles++;
        if (bcs && scs) overlap++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int who, input logic cs, input logic rnw,
                                 input logic [15:0] addr, input logic [7:0] data);
        case (who)
            M: begin main_cs = cs; main_rnw = rnw; main_addr = addr[9:0]; main_dout = data; end
            S: begin sub_cs = cs; sub_rnw = rnw; sub_addr = addr[9:0]; sub_dout = data; end
            default: begin snd_cs = cs; snd_rnw = rnw; snd_addr = addr; snd_dout = data; end
        endcase
    endtask

    function automatic logic okOf(input int who);
        case (who)
            M:       return main_ok;
            S:       return sub_ok;
            default: return snd_ok;
        endcase
    endfunction

    task automatic waitOk(input int who, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget && !okOf(who)) begin
            tick(1);
            cycles++;
        end
    endtask

    initial begin
        int cyc, n, snap;
        int order[3];
        int exp_order[3];
        int ok_cnt[3];

`ifdef JTSHOUSE_CUS30_SNDPRIO_EN
        exp_order = '{N, S, M};
`else
        exp_order = '{M, S, N};
`endif
        ok_cnt = '{0, 0, 0};

        rst = 1'b1;
        applyStimulus(M, 1'b0, 1'b1, 16'h0, 8'h0);
        applyStimulus(S, 1'b0, 1'b1, 16'h0, 8'h0);
        applyStimulus(N, 1'b0, 1'b1, 16'h0, 8'h0);
        tick(3);
        checkOutput("rst_bcs", bcs, 1'b0);
        checkOutput("rst_scs", scs, 1'b0);
        checkOutput("rst_bsel", bsel, 1'b0);
        checkOutput("rst_brnw", brnw, 1'b1);
        checkOutput("rst_srnw", srnw, 1'b1);
        checkOutput("rst_oks", {main_ok, sub_ok, snd_ok}, 3'b000);
        checkOutput("rst_din", {main_din, sub_din, snd_din}, 24'h0);
        checkOutput("rst_addr", {baddr, saddr}, 26'h0);
        rst = 1'b0;
        tick(1);

        // Main read of 10'h041, no contention
        snap = bcs_cycles;
        applyStimulus(M, 1'b1, 1'b1, 16'h041, 8'h00);
        tick(1);
        checkOutput("t1_acc_bcs", bcs, 1'b1);
        checkOutput("t1_acc_bsel", bsel, 1'b1);
        checkOutput("t1_acc_baddr", baddr, 10'h041);
        checkOutput("t1_acc_ok", main_ok, 1'b0);
        tick(1);
        checkOutput("t1_latch_bcs", bcs, 1'b0);
        checkOutput("t1_latch_ok", main_ok, 1'b0);
        tick(1);
        checkOutput("t1_ok", main_ok, 1'b1);
        checkOutput("t1_din", main_din, 8'h5A);
        applyStimulus(M, 1'b0, 1'b1, 16'h041, 8'h00);
        tick(1);
        checkOutput("t1_ok_clear", main_ok, 1'b0);
        checkOutput("t1_din_hold", main_din, 8'h5A);
        checkOutput("t1_bcs_pulses", bcs_cycles - snap, 1);
        tick(3);

        // Sound write then read of 16'h0123
        snap = scs_cycles;
        applyStimulus(N, 1'b1, 1'b0, 16'h0123, 8'hC3);
        tick(1);
        checkOutput("t2_scs", scs, 1'b1);
        checkOutput("t2_bsel", bsel, 1'b0);
        checkOutput("t2_saddr", saddr, 16'h0123);
        checkOutput("t2_wr", {srnw, sdout}, 9'h0C3);
        waitOk(N, 8, cyc);
        checkOutput("t2_wr_lat", cyc, 2);
        applyStimulus(N, 1'b0, 1'b0, 16'h0123, 8'hC3);
        tick(1);
        checkOutput("t2_ok_clear", snd_ok, 1'b0);
        tick(3);
        applyStimulus(N, 1'b1, 1'b1, 16'h0123, 8'h00);
        waitOk(N, 8, cyc);
        checkOutput("t2_rd_lat", cyc, 3);
        checkOutput("t2_rd_din", snd_din, 8'hC3);
        applyStimulus(N, 1'b0, 1'b1, 16'h0123, 8'h00);
        tick(1);
        checkOutput("t2_scs_pulses", scs_cycles - snap, 2);
        tick(3);

        // Three simultaneous requesters, four passes
        for (int pass = 0; pass < 4; pass++) begin
            order = '{-1, -1, -1};
            n = 0;
            cyc = 0;
            applyStimulus(M, 1'b1, 1'b1, 16'h010, 8'h00);
            applyStimulus(S, 1'b1, 1'b1, 16'h020, 8'h00);
            applyStimulus(N, 1'b1, 1'b1, 16'h030, 8'h00);
            while (n < 3 && cyc < 40) begin
                tick(1);
                cyc++;
                if (main_cs && main_ok) begin order[n] = M; n++; ok_cnt[M]++; main_cs = 1'b0; end
                if (sub_cs && sub_ok)   begin order[n] = S; n++; ok_cnt[S]++; sub_cs = 1'b0; end
                if (snd_cs && snd_ok)   begin order[n] = N; n++; ok_cnt[N]++; snd_cs = 1'b0; end
            end
            checkOutput("t3_grants", n, 3);
            checkOutput("t3_order0", order[0], exp_order[0]);
            checkOutput("t3_order1", order[1], exp_order[1]);
            checkOutput("t3_order2", order[2], exp_order[2]);
            tick(2);
        end
        checkOutput("t3_main_oks", ok_cnt[M], 4);
        checkOutput("t3_sub_oks", ok_cnt[S], 4);
        checkOutput("t3_snd_oks", ok_cnt[N], 4);
        checkOutput("t3_dins", {main_din, sub_din, snd_din}, 24'h0B3B2B);
        checkOutput("t3_overlap", overlap, 0);

        // Sub drops cs during LATCH of a write while main waits
        applyStimulus(S, 1'b1, 1'b0, 16'h2A0, 8'h11);
        tick(1);
        checkOutput("t4_acc", {bcs, brnw, baddr, bdout}, {1'b1, 1'b0, 10'h2A0, 8'h11});
        applyStimulus(M, 1'b1, 1'b1, 16'h041, 8'h00);
        tick(1);
        applyStimulus(S, 1'b0, 1'b0, 16'h2A0, 8'h11);
        tick(1);
        checkOutput("t4_sub_ok", sub_ok, 1'b0);
        waitOk(M, 10, cyc);
        checkOutput("t4_main_lat", cyc, 5);
        checkOutput("t4_main_din", main_din, 8'h5A);
        checkOutput("t4_ram", ram[10'h2A0], 8'h11);
        applyStimulus(M, 1'b0, 1'b1, 16'h041, 8'h00);
        tick(3);

        // Reset during ACC, then a clean restart
        applyStimulus(M, 1'b1, 1'b1, 16'h041, 8'h00);
        tick(1);
        checkOutput("t5_acc_bcs", bcs, 1'b1);
        rst = 1'b1;
        tick(1);
        checkOutput("t5_rst_strobes", {bcs, scs}, 2'b00);
        checkOutput("t5_rst_oks", {main_ok, sub_ok, snd_ok}, 3'b000);
        checkOutput("t5_rst_din", main_din, 8'h00);
        checkOutput("t5_rst_bus", {bsel, brnw}, 2'b01);
        rst = 1'b0;
        main_cs = 1'b0;
        tick(1);
        checkOutput("t5_no_strobe", {bcs, scs}, 2'b00);
        applyStimulus(M, 1'b1, 1'b1, 16'h041, 8'h00);
        waitOk(M, 8, cyc);
        checkOutput("t5_restart_lat", cyc, 3);
        checkOutput("t5_restart_din", main_din, 8'h5A);
        applyStimulus(M, 1'b0, 1'b1, 16'h041, 8'h00);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
